// File: rtl/axi_lite_reg_bridge.sv
// axi_lite_reg_bridge: AXI4-Lite slave that turns AXI reads and writes into
// single-outstanding requests on a simple req/ack register bus.
// AW, W and AR each have a one-entry holding register. When a read and a write
// are both pending, they are served in round-robin order.
// Optional feature macro: AXI_LITE_REG_BRIDGE_TIMEOUT_EN. When it is defined, a
// request that gets no ack within TIMEOUT_CYCLES cycles completes with SLVERR.
module axi_lite_reg_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic [2:0]            s_arprot,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_W-1:0]     reg_addr,
  output logic [DATA_W-1:0]     reg_wdata,
  output logic [DATA_W/8-1:0]   reg_wstrb,
  input  logic                  reg_ack,
  input  logic [DATA_W-1:0]     reg_rdata,
  input  logic                  reg_err
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_last_rd;   // 0: the last transaction served was a write
  logic                r_aw_full;
  logic                r_w_full;
  logic                r_ar_full;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [ADDR_W-1:0]   r_araddr;

  logic                w_serve_wr;
  logic                w_serve_rd;
  logic                w_timeout;
  logic                w_aw_full_nxt;
  logic                w_w_full_nxt;
  logic                w_ar_full_nxt;
  logic                w_unused;

  // The protection bits are not used by this bridge.
  assign w_unused = &{1'b0, s_awprot, s_arprot, (TIMEOUT_CYCLES >= 1)};

  // Choose which pending transaction IDLE starts; a tie goes to the type not served last.
  always_comb begin
    w_serve_wr = 1'b0;
    w_serve_rd = 1'b0;
    if (r_state == ST_IDLE) begin
      if (r_aw_full && r_w_full && r_ar_full) begin
        if (r_last_rd) begin
          w_serve_wr = 1'b1;
        end else begin
          w_serve_rd = 1'b1;
        end
      end else if (r_aw_full && r_w_full) begin
        w_serve_wr = 1'b1;
      end else if (r_ar_full) begin
        w_serve_rd = 1'b1;
      end else begin
        w_serve_wr = 1'b0;
      end
    end else begin
      w_serve_rd = 1'b0;
    end
  end

  // Next-state full flags: a handshake fills an entry and the FSM empties it.
  always_comb begin
    w_aw_full_nxt = r_aw_full;
    w_w_full_nxt  = r_w_full;
    w_ar_full_nxt = r_ar_full;
    if (s_awvalid && s_awready) begin
      w_aw_full_nxt = 1'b1;
    end else if (w_serve_wr) begin
      w_aw_full_nxt = 1'b0;
    end else begin
      w_aw_full_nxt = r_aw_full;
    end
    if (s_wvalid && s_wready) begin
      w_w_full_nxt = 1'b1;
    end else if (w_serve_wr) begin
      w_w_full_nxt = 1'b0;
    end else begin
      w_w_full_nxt = r_w_full;
    end
    if (s_arvalid && s_arready) begin
      w_ar_full_nxt = 1'b1;
    end else if (w_serve_rd) begin
      w_ar_full_nxt = 1'b0;
    end else begin
      w_ar_full_nxt = r_ar_full;
    end
  end

  // Holding registers, their full flags and the registered readies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_araddr  <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_arready <= 1'b0;
    end else begin
      r_aw_full <= w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      r_ar_full <= w_ar_full_nxt;
      s_awready <= ~w_aw_full_nxt;
      s_wready  <= ~w_w_full_nxt;
      s_arready <= ~w_ar_full_nxt;
      if (s_awvalid && s_awready) r_awaddr <= s_awaddr;
      if (s_wvalid && s_wready) begin
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
      end
      if (s_arvalid && s_arready) r_araddr <= s_araddr;
    end
  end

`ifdef AXI_LITE_REG_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;

  // The timeout fires on the cycle in which the wait count would reach TIMEOUT_CYCLES.
  assign w_timeout = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count the cycles without an ack while a request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_serve_wr || w_serve_rd) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_WR_REQ || r_state == ST_RD_REQ) && !reg_ack) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Main transaction FSM, with the register-bus and response outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last_rd <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= 2'b00;
      s_rvalid  <= 1'b0;
      s_rresp   <= 2'b00;
      s_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_serve_rd) begin
            r_state   <= ST_RD_REQ;
            reg_req   <= 1'b1;
            reg_we    <= 1'b0;
            reg_addr  <= r_araddr;
            reg_wdata <= '0;
            reg_wstrb <= '0;
          end else if (w_serve_wr) begin
            r_state   <= ST_WR_REQ;
            reg_req   <= 1'b1;
            reg_we    <= 1'b1;
            reg_addr  <= r_awaddr;
            reg_wdata <= r_wdata;
            reg_wstrb <= r_wstrb;
          end
        end
        ST_WR_REQ: begin
          if (reg_ack) begin
            reg_req  <= 1'b0;
            s_bresp  <= reg_err ? 2'b10 : 2'b00;
            s_bvalid <= 1'b1;
            r_state  <= ST_WR_RESP;
          end else if (w_timeout) begin
            reg_req  <= 1'b0;
            s_bresp  <= 2'b10;
            s_bvalid <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_RD_REQ: begin
          if (reg_ack) begin
            reg_req  <= 1'b0;
            s_rresp  <= reg_err ? 2'b10 : 2'b00;
            s_rdata  <= reg_rdata;
            s_rvalid <= 1'b1;
            r_state  <= ST_RD_RESP;
          end else if (w_timeout) begin
            reg_req  <= 1'b0;
            s_rresp  <= 2'b10;
            s_rdata  <= '0;
            s_rvalid <= 1'b1;
            r_state  <= ST_RD_RESP;
          end
        end
        ST_WR_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            r_last_rd <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_RD_RESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            r_last_rd <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Self-checking bench for axi_lite_reg_bridge: directed scenarios followed by
// random contention rounds, all checked against a transaction-level model.
module tb_axi_lite_reg_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef AXI_LITE_REG_BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] s_awaddr = '0;
  logic [2:0]    s_awprot = 3'd0;
  logic          s_awvalid = 1'b0;
  logic          s_awready;
  logic [DW-1:0] s_wdata = '0;
  logic [SW-1:0] s_wstrb = '0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready = 1'b0;
  logic [AW-1:0] s_araddr = '0;
  logic [2:0]    s_arprot = 3'd0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready = 1'b0;
  logic          reg_req;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [SW-1:0] reg_wstrb;
  logic          reg_ack = 1'b0;
  logic [DW-1:0] reg_rdata = '0;
  logic          reg_err = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  bit model_last_rd = 1'b0;   // the type served last; reset means write

  axi_lite_reg_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the end of the test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise the requested valids and drop each one after its handshake edge.
  task automatic present(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [AW-1:0] awa, input logic [DW-1:0] wd,
                         input logic [SW-1:0] ws, input logic [AW-1:0] ara);
    int n = 0;
    bit hs_aw, hs_w, hs_ar;
    if (do_aw) begin s_awaddr = awa; s_awvalid = 1'b1; end
    if (do_w)  begin s_wdata = wd; s_wstrb = ws; s_wvalid = 1'b1; end
    if (do_ar) begin s_araddr = ara; s_arvalid = 1'b1; end
    while ((s_awvalid || s_wvalid || s_arvalid) && n < 20) begin
      hs_aw = s_awvalid && s_awready;
      hs_w  = s_wvalid && s_wready;
      hs_ar = s_arvalid && s_arready;
      tick();
      if (hs_aw) s_awvalid = 1'b0;
      if (hs_w)  s_wvalid = 1'b0;
      if (hs_ar) s_arvalid = 1'b0;
      n++;
    end
    check("handshake_done", {s_awvalid, s_wvalid, s_arvalid}, 3'b000);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
  endtask

  task automatic wait_req;
    int n = 0;
    while (!reg_req && n < 30) begin
      tick();
      n++;
    end
    check("req_seen", reg_req, 1'b1);
  endtask

  // Serve one register request as the peripheral, then complete the AXI response.
  task automatic serve_one(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input bit err, input logic [DW-1:0] rdat,
                           input int ack_dly, input int rdy_dly);
    logic [1:0] exp_resp;
    exp_resp = err ? 2'b10 : 2'b00;
    wait_req();
    check("reg_we", reg_we, is_wr);
    check("reg_addr", reg_addr, addr);
    if (is_wr) begin
      check("reg_wdata", reg_wdata, data);
      check("reg_wstrb", reg_wstrb, strb);
    end
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      check("req_hold", reg_req, 1'b1);
      check("addr_hold", reg_addr, addr);
    end
    reg_ack = 1'b1; reg_err = err; reg_rdata = rdat;
    tick();
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = $urandom();
    check("req_drop", reg_req, 1'b0);
    for (int i = 0; i <= rdy_dly; i++) begin
      if (is_wr) begin
        check("bvalid", s_bvalid, 1'b1);
        check("bresp", s_bresp, exp_resp);
        check("rvalid_idle", s_rvalid, 1'b0);
      end else begin
        check("rvalid", s_rvalid, 1'b1);
        check("rresp", s_rresp, exp_resp);
        check("rdata", s_rdata, rdat);
        check("bvalid_idle", s_bvalid, 1'b0);
      end
      if (i == rdy_dly) begin
        if (is_wr) s_bready = 1'b1; else s_rready = 1'b1;
      end
      tick();
    end
    s_bready = 1'b0; s_rready = 1'b0;
    check("valid_clear", {s_bvalid, s_rvalid}, 2'b00);
    if (!is_wr) check("rdata_kept", s_rdata, rdat);
    model_last_rd = !is_wr;
  endtask

  initial begin
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rd;
    logic [SW-1:0] ws;
    int kind, cyc;
    bit first_rd;

    // Reset state
    tick(); tick();
    check("rst_readies", {s_awready, s_wready, s_arready}, 3'b000);
    check("rst_valids", {s_bvalid, s_rvalid, reg_req}, 3'b000);
    check("rst_regbus", {reg_we, reg_addr, reg_wstrb}, '0);
    check("rst_resp", {s_bresp, s_rresp, s_rdata}, '0);
    rst = 1'b0;
    tick();
    check("readies_after_rst", {s_awready, s_wready, s_arready}, 3'b111);

    // Write with AW and W in the same cycle, acked after 3 cycles
    present(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    check("ready_drop", {s_awready, s_wready}, 2'b00);
    check("req_latency", reg_req, 1'b0);
    serve_one(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_b", {s_bvalid, reg_req}, 2'b00);
    end

    // W arrives 4 cycles before AW
    present(1'b0, 1'b1, 1'b0, 32'h0, 32'hCAFE0001, 4'h3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_req_w_only", reg_req, 1'b0);
      check("wready_held_low", s_wready, 1'b0);
    end
    present(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'h0, 32'h0);
    serve_one(1'b1, 32'h44, 32'hCAFE0001, 4'h3, 1'b0, 32'h0, 1, 1);

    // Read with error and rready held low for 5 cycles
    present(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h20);
    serve_one(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h12345678, 2, 5);

    // reg_ack outside a request is ignored
    reg_ack = 1'b1; reg_err = 1'b1;
    tick();
    reg_ack = 1'b0; reg_err = 1'b0;
    tick();
    check("stray_ack", {s_bvalid, s_rvalid, reg_req}, 3'b000);

    // Reset pulsed while a write request is outstanding
    present(1'b1, 1'b1, 1'b0, 32'h80, 32'h55AA55AA, 4'hF, 32'h0);
    wait_req();
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", {reg_req, reg_we, reg_addr}, '0);
    check("async_rst_ready", {s_awready, s_wready, s_arready, s_bvalid}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    model_last_rd = 1'b0;
    tick();
    check("ready_after_mid_rst", {s_awready, s_wready, s_arready}, 3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_b_after_rst", {s_bvalid, reg_req}, 2'b00);
    end

    // Read and write pending together after reset: the read goes first
    present(1'b1, 1'b1, 1'b1, 32'h100, 32'h01020304, 4'h5, 32'h200);
    serve_one(1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5, 0, 0);
    serve_one(1'b1, 32'h100, 32'h01020304, 4'h5, 1'b0, 32'h0, 0, 0);

    // Random rounds: the model serves the lone pending type, or alternates on a tie
    for (int r = 0; r < 16; r++) begin
      kind = $urandom_range(0, 2);
      wa = $urandom(); ra = $urandom(); wd = $urandom(); rd = $urandom();
      ws = SW'($urandom());
      present(kind != 1, kind != 1, kind != 0, wa, wd, ws, ra);
      if (kind == 2) first_rd = !model_last_rd;
      else first_rd = (kind == 1);
      if (first_rd)
        serve_one(1'b0, ra, '0, '0, 1'($urandom()), rd, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        serve_one(1'b1, wa, wd, ws, 1'($urandom()), '0, $urandom_range(0, 3), $urandom_range(0, 3));
      if (kind == 2) begin
        if (first_rd)
          serve_one(1'b1, wa, wd, ws, 1'($urandom()), '0, $urandom_range(0, 3), $urandom_range(0, 3));
        else
          serve_one(1'b0, ra, '0, '0, 1'($urandom()), rd, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

`ifdef AXI_LITE_REG_BRIDGE_TIMEOUT_EN
    // No ack: SLVERR arrives TO cycles after reg_req rises
    present(1'b1, 1'b1, 1'b0, 32'h300, 32'h77, 4'h1, 32'h0);
    wait_req();
    cyc = 0;
    while (!s_bvalid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("timeout_cycles", cyc, TO);
    check("timeout_bresp", s_bresp, 2'b10);
    check("timeout_req_drop", reg_req, 1'b0);
    s_bready = 1'b1; tick(); s_bready = 1'b0;
    model_last_rd = 1'b0;
    present(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h304);
    wait_req();
    cyc = 0;
    while (!s_rvalid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("timeout_rd_cycles", cyc, TO);
    check("timeout_rresp", s_rresp, 2'b10);
    check("timeout_rdata", s_rdata, 32'h0);
    s_rready = 1'b1; tick(); s_rready = 1'b0;
`else
    cyc = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
